mont_domain_conv: RTL and testbench

MONT_DOMAIN_CONV -- requirements
Module: mont_domain_conv

---
 rtl/mont_pkg.sv | 17 +
 rtl/mont_iter_step.sv | 33 +++
 rtl/mont_domain_conv.sv | 155 +++++++++++++++
 tb/tb_mont_domain_conv.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery domain converter: default width,
// FSM state encoding and conversion-direction encodings.
package mont_pkg;

  localparam int WIDTH_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ITER   = 2'd1,
    ST_REDUCE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic MODE_TO_MONT   = 1'b0;
  localparam logic MODE_FROM_MONT = 1'b1;

endpackage

// File: rtl/mont_iter_step.sv
// One radix-2 Montgomery step: S += a_i*B; if S odd then S += N; S >>= 1.
// Purely combinational; S is WIDTH+2 bits so the sum never overflows.
module mont_iter_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] s,
  input  logic             a_i,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] s_next
);

  logic [WIDTH+1:0] add_b_s;
  logic [WIDTH+1:0] add_n_s;

  // conditional add of B, parity-driven add of N, then halve
  always_comb begin
    add_b_s = s;
    add_n_s = s;
    if (a_i) begin
      add_b_s = s + {2'b00, b};
    end else begin
      add_b_s = s;
    end
    if (add_b_s[0]) begin
      add_n_s = add_b_s + {2'b00, n};
    end else begin
      add_n_s = add_b_s;
    end
    s_next = {1'b0, add_n_s[WIDTH+1:1]};
  end

endmodule

// File: rtl/mont_domain_conv.sv
// Bit-serial Montgomery domain converter (a*R mod N or a*R^-1 mod N).
// Optional MONT_CONV_ODD_CHECK_EN: reject even moduli with err and a short done.
module mont_domain_conv
  import mont_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] N_in,
  input  logic [WIDTH-1:0] R_t,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int SW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_r;
  state_t           state_s;
  logic [SW-1:0]    s_r;
  logic [SW-1:0]    s_step_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] rt_r;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] result_r;
  logic             mode_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             n_even_s;
  logic [CW-1:0]    count_r;

`ifdef MONT_CONV_ODD_CHECK_EN
  assign n_even_s = ~N_in[0];
`else
  assign n_even_s = 1'b0;
`endif

  assign b_s = (mode_r == MODE_FROM_MONT) ? {{(WIDTH-1){1'b0}}, 1'b1} : rt_r;

  mont_iter_step #(.WIDTH(WIDTH)) u_step (
    .s      (s_r),
    .a_i    (a_r[0]),
    .b      (b_s),
    .n      (n_r),
    .s_next (s_step_s)
  );

  // next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = n_even_s ? ST_DONE : ST_ITER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ITER: begin
        if (count_r == CW'(1)) begin
          state_s = ST_REDUCE;
        end else begin
          state_s = ST_ITER;
        end
      end
      ST_REDUCE: state_s = ST_DONE;
      // DONE lingers while count is non-zero; only the even-N path loads it
      ST_DONE: begin
        if (count_r == {CW{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // datapath, counter and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      s_r      <= {SW{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      n_r      <= {WIDTH{1'b0}};
      rt_r     <= {WIDTH{1'b0}};
      mode_r   <= 1'b0;
      count_r  <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r    <= a_in;
            n_r    <= N_in;
            rt_r   <= R_t;
            mode_r <= mode;
            s_r    <= {SW{1'b0}};
            busy_r <= 1'b1;
            err_r  <= n_even_s;
            if (n_even_s) begin
              count_r  <= CW'(1);
              result_r <= {WIDTH{1'b0}};
            end else begin
              count_r <= CW'(WIDTH);
            end
          end
        end
        ST_ITER: begin
          s_r     <= s_step_s;
          a_r     <= {1'b0, a_r[WIDTH-1:1]};
          count_r <= count_r - CW'(1);
        end
        // S < 2N here, so one conditional subtraction completes the reduction
        ST_REDUCE: begin
          if (s_r >= {2'b00, n_r}) begin
            result_r <= WIDTH'(s_r - {2'b00, n_r});
          end else begin
            result_r <= s_r[WIDTH-1:0];
          end
        end
        ST_DONE: begin
          if (count_r == {CW{1'b0}}) begin
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            count_r <= count_r - CW'(1);
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;

endmodule

// File: tb/tb_mont_domain_conv.sv
// Self-checking bench for mont_domain_conv (WIDTH = 8) using a scoreboard
// queue filled at start and drained when done pulses.
module tb_mont_domain_conv;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         err;
    logic         chk_res;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a_in;
  logic [W-1:0] n_in;
  logic [W-1:0] r_t;
  logic [W-1:0] result;
  logic         busy;
  logic         done;
  logic         err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  mont_domain_conv #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a_in   (a_in),
    .N_in   (n_in),
    .R_t    (r_t),
    .result (result),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Reference: mode 0 -> a*R mod n; mode 1 -> x with x*R == a (mod n), R = 256
  function automatic int exp_conv(input int m, input int a, input int n);
    int r;
    r = 256 % n;
    if (m == 0) return (a * r) % n;
    for (int x = 0; x < n; x++) begin
      if ((x * r) % n == a) return x;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic start_op(input int m, input int a, input int n, input bit push);
    exp_t e;
    e.res     = W'(exp_conv(m, a, n));
    e.err     = 1'b0;
    e.chk_res = 1'b1;
    if (n % 2 == 0) begin
`ifdef MONT_CONV_ODD_CHECK_EN
      e.res = '0; e.err = 1'b1; e.chk_res = 1'b1;
`else
      e.res = '0; e.err = 1'b0; e.chk_res = 1'b0;
`endif
    end
    if (push) exp_q.push_back(e);
    mode  = m[0];
    a_in  = a[W-1:0];
    n_in  = n[W-1:0];
    r_t   = W'((65536 % n));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int elapsed, input int exp_lat);
    int   cyc;
    exp_t e;
    cyc = elapsed;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    chk("done_seen", int'(done), 1);
    chk("latency", cyc, exp_lat);
    if (exp_q.size() == 0) begin
      chk("sb_nonempty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      if (e.chk_res) chk("result", int'(result), int'(e.res));
      chk("err", int'(err), int'(e.err));
    end
  endtask

  initial begin
    int done_cnt;
    int nlist[4];
    int n, a, m;
    nlist[0] = 13; nlist[1] = 251; nlist[2] = 97; nlist[3] = 255;

    rst = 1'b1; start = 1'b0; mode = 1'b0; a_in = '0; n_in = '0; r_t = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);

    // a = 5 into the domain: 6 after 10 cycles
    start_op(0, 5, 13, 1'b1);
    chk("busy_after_start", int'(busy), 1);
    wait_done(0, 10);
    chk("req22_result", int'(result), 6);
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(done), 0);
    chk("busy_low_after", int'(busy), 0);
    chk("result_held", int'(result), 6);

    // back-to-back starts in the cycle after done
    start_op(1, 6, 13, 1'b1);
    wait_done(0, 10);
    chk("req23_a6", int'(result), 5);
    start_op(1, 9, 13, 1'b1);
    wait_done(0, 10);
    chk("req23_a9", int'(result), 1);
    start_op(0, 0, 13, 1'b1);
    wait_done(0, 10);
    start_op(1, 0, 13, 1'b1);
    wait_done(0, 10);

    // start pulsed mid-ITER with other inputs must be ignored
    start_op(0, 5, 13, 1'b1);
    mode = 1'b1; a_in = 8'd7; n_in = 8'd11; r_t = 8'd1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_mid_iter", int'(busy), 1);
    wait_done(3, 10);
    chk("ignored_restart", int'(result), 6);

    for (int i = 0; i < 6; i++) begin
      n = nlist[i % 4];
      a = int'($urandom_range(n - 1, 0));
      m = i % 2;
      start_op(m, a, n, 1'b1);
      wait_done(0, 10);
    end

    // reset during ITER aborts with no done and clears outputs
    start_op(0, 5, 13, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_result", int'(result), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 0);
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    // even modulus
    start_op(0, 5, 12, 1'b1);
`ifdef MONT_CONV_ODD_CHECK_EN
    wait_done(0, 2);
`else
    wait_done(0, 10);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
